fetch_loader: RTL and testbench

FETCH_LOADER -- requirements
Module: fetch_loader

---
 rtl/fetch_loader.sv | 198 +++++++++++++++++++
 tb/tb_fetch_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_loader.sv
// Program loader and instruction fetch port: copies a program from an external source memory
// into local instruction memory, then serves fetches. Define FETCH_BOUNDS_EN for fetch checks.
module fetch_loader #(
    parameter int unsigned       ADDR_W   = 14,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       READ_LAT = 1,
    parameter logic [DATA_W-1:0] END_WORD = DATA_W'(32'h0000003F)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [2:0]        mode,
    input  logic [31:0]       pc,
    input  logic              fetch_req,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_dout,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              done,
    output logic [ADDR_W:0]   load_count,
    output logic              fault
);

    localparam int unsigned Depth  = 2 ** ADDR_W;
    localparam int unsigned CountW = ADDR_W + 1;
    localparam logic [2:0]  ModeLoad = 3'd1;
    localparam logic [2:0]  ModeExec = 3'd2;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        wait_cnt_q;
    logic [ADDR_W:0]   load_count_q;
    logic [ADDR_W-1:0] src_addr_q;
    logic              done_q;
    logic [DATA_W-1:0] inst_q;
    logic              inst_valid_q;
    logic [DATA_W-1:0] mem [Depth];

    logic              in_load, in_exec;
    logic              wait_last, last_word;
    logic              start_load, issue, wait_step, store, abort;
    logic              fetch;
    logic [ADDR_W-1:0] fetch_idx;
    logic [DATA_W-1:0] fetch_data;
    logic              unused_pc;

    assign in_load   = (mode == ModeLoad);
    assign in_exec   = (mode == ModeExec);
    assign wait_last = (wait_cnt_q == 2'(READ_LAT - 1));
    // The terminator itself is stored and counted before the load completes.
    assign last_word = (src_dout == END_WORD) ||
                       (load_count_q == CountW'(Depth - 1));

    assign fetch     = in_exec && fetch_req;
    assign fetch_idx = pc[ADDR_W+1:2];
    assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_load) state_d = StIssue;
            end
            StIssue: begin
                state_d = in_load ? StWait : StIdle;
            end
            StWait: begin
                if (!in_load) begin
                    state_d = StIdle;
                end else if (wait_last) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (!in_load) begin
                    state_d = StIdle;
                end else if (last_word) begin
                    state_d = StDone;
                end else begin
                    state_d = StIssue;
                end
            end
            StDone: begin
                if (!in_load) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control outputs of the load sequencer
    always_comb begin
        start_load = 1'b0;
        issue      = 1'b0;
        wait_step  = 1'b0;
        store      = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            StIdle: start_load = in_load;
            StIssue: begin
                issue = in_load;
                abort = !in_load;
            end
            StWait: begin
                wait_step = in_load;
                abort     = !in_load;
            end
            StWrite: begin
                store = in_load;
                abort = !in_load;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_count_q <= '0;
            src_addr_q   <= '0;
            wait_cnt_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            if (start_load) begin
                load_count_q <= '0;
                src_addr_q   <= '0;
                done_q       <= 1'b0;
            end
            if (issue) begin
                src_addr_q <= load_count_q[ADDR_W-1:0];
                wait_cnt_q <= '0;
            end
            if (wait_step) begin
                wait_cnt_q <= wait_cnt_q + 2'd1;
            end
            if (store) begin
                load_count_q <= load_count_q + CountW'(1);
                if (last_word) done_q <= 1'b1;
            end
            if (abort) begin
                done_q <= 1'b0;
            end
        end
    end

    // Instruction memory survives reset so a program can be re-run.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[load_count_q[ADDR_W-1:0]] <= src_dout;
        end
    end

`ifdef FETCH_BOUNDS_EN
    logic fetch_bad;
    logic fault_q;

    assign fetch_bad  = (pc[1:0] != 2'b00) || ({1'b0, fetch_idx} >= load_count_q);
    assign fetch_data = fetch_bad ? '0 : mem[fetch_idx];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault_q <= 1'b0;
        end else if (fetch && fetch_bad) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign fetch_data = mem[fetch_idx];
    assign fault      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            inst_valid_q <= fetch;
            if (fetch) inst_q <= fetch_data;
        end
    end

    assign src_addr   = src_addr_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign done       = done_q;
    assign load_count = load_count_q;

endmodule

// File: tb/tb_fetch_loader.sv
// Bench for fetch_loader: a default-sized instance (READ_LAT=1) and a tiny one (ADDR_W=2,
// READ_LAT=3), each fed by a latency-accurate source memory and checked against a word model.
module tb_fetch_loader;

    localparam int unsigned AwA      = 14;
    localparam int unsigned DepthA   = 1 << AwA;
    localparam logic [31:0] EndWord  = 32'h0000003F;
    localparam logic [2:0]  ModeStall = 3'd0;
    localparam logic [2:0]  ModeLoad  = 3'd1;
    localparam logic [2:0]  ModeExec  = 3'd2;

    logic        clk, rstn;
    logic [2:0]  mode_a, mode_b;
    logic [31:0] pc_a, pc_b;
    logic        req_a, req_b;
    logic [13:0] src_addr_a;
    logic [1:0]  src_addr_b;
    logic [31:0] src_dout_a, src_dout_b, inst_a, inst_b;
    logic        inst_valid_a, inst_valid_b, done_a, done_b, fault_a, fault_b;
    logic [14:0] load_count_a;
    logic [2:0]  load_count_b;

    logic [31:0] srcmem_a [64];
    logic [31:0] srcmem_b [4];
    logic [31:0] pipe_b1, pipe_b2;
    logic [31:0] model_mem_a [DepthA];

    int unsigned exp_cnt_a;
    logic        exp_fault;
    logic [31:0] exp_inst_a;
    int          n_vec = 0;
    int          n_bad = 0;

    fetch_loader #(.ADDR_W(14), .DATA_W(32), .READ_LAT(1), .END_WORD(32'h3F)) u_a (
        .clk(clk), .rstn(rstn), .mode(mode_a), .pc(pc_a), .fetch_req(req_a),
        .src_addr(src_addr_a), .src_dout(src_dout_a), .inst(inst_a),
        .inst_valid(inst_valid_a), .done(done_a), .load_count(load_count_a), .fault(fault_a)
    );

    fetch_loader #(.ADDR_W(2), .DATA_W(32), .READ_LAT(3), .END_WORD(32'h3F)) u_b (
        .clk(clk), .rstn(rstn), .mode(mode_b), .pc(pc_b), .fetch_req(req_b),
        .src_addr(src_addr_b), .src_dout(src_dout_b), .inst(inst_b),
        .inst_valid(inst_valid_b), .done(done_b), .load_count(load_count_b), .fault(fault_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memories: data appears READ_LAT clock edges after the address.
    always @(posedge clk) src_dout_a <= srcmem_a[src_addr_a[5:0]];
    always @(posedge clk) begin
        pipe_b1    <= srcmem_b[src_addr_b];
        pipe_b2    <= pipe_b1;
        src_dout_b <= pipe_b2;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == EndWord) w = w + 32'd1;
        return w;
    endfunction

    // Word model of a fetch: index wraps modulo depth; bounds rules only when enabled.
    task automatic model_fetch_a(input logic [31:0] p, output logic [31:0] w);
        int unsigned idx;
        idx = (p / 4) % DepthA;
        w   = model_mem_a[idx];
`ifdef FETCH_BOUNDS_EN
        if ((p % 4) != 0 || idx >= exp_cnt_a) begin
            w         = '0;
            exp_fault = 1'b1;
        end
`endif
    endtask

    task automatic fetch_a(input logic [31:0] p, input logic rq, input string tag);
        logic [31:0] e;
        e      = '0;
        mode_a = ModeExec;
        pc_a   = p;
        req_a  = rq;
        if (rq) model_fetch_a(p, e);
        tick();
        if (rq) exp_inst_a = e;
        chk({tag, "_valid"}, 64'(inst_valid_a), 64'(rq));
        chk({tag, "_inst"}, 64'(inst_a), 64'(exp_inst_a));
        chk({tag, "_fault"}, 64'(fault_a), 64'(exp_fault));
    endtask

    // Load whatever srcmem_a holds; expected length is found by scanning for the terminator.
    task automatic load_a(input string tag);
        int unsigned n;
        int unsigned edges;
        n = 0;
        while (n < DepthA) begin
            n++;
            if (srcmem_a[n-1] == EndWord) break;
        end
        mode_a = ModeLoad;
        req_a  = 1'b0;
        tick();
        edges = 1;
        chk({tag, "_start_addr"}, 64'(src_addr_a), 64'd0);
        chk({tag, "_start_cnt"}, 64'(load_count_a), 64'd0);
        chk({tag, "_start_done"}, 64'(done_a), 64'd0);
        while (done_a !== 1'b1 && edges < 2000) begin
            tick();
            edges++;
        end
        // One edge leaves IDLE, then each word costs READ_LAT+2 = 3 cycles.
        chk({tag, "_cycles"}, 64'(edges), 64'(1 + 3 * n));
        chk({tag, "_count"}, 64'(load_count_a), 64'(n));
        for (int i = 0; i < int'(n); i++) model_mem_a[i] = srcmem_a[i];
        exp_cnt_a = n;
        mode_a = ModeStall;
        tick();
        chk({tag, "_done_hold"}, 64'(done_a), 64'd1);
    endtask

    initial begin
        int unsigned len, idx, k, edges;
        logic [31:0] p;

        rstn   = 1'b0;
        mode_a = ModeStall;
        mode_b = ModeStall;
        pc_a   = '0;
        pc_b   = '0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        for (int i = 0; i < 64; i++) srcmem_a[i] = rnd_word();
        for (int i = 0; i < 4; i++) srcmem_b[i] = rnd_word();
        exp_cnt_a  = 0;
        exp_fault  = 1'b0;
        exp_inst_a = '0;

        tick();
        tick();
        chk("rst_src_addr", 64'(src_addr_a), 64'd0);
        chk("rst_inst", 64'(inst_a), 64'd0);
        chk("rst_valid", 64'(inst_valid_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_count", 64'(load_count_a), 64'd0);
        chk("rst_fault", 64'(fault_a), 64'd0);
        rstn = 1'b1;
        tick();

        // Three-word program ending in the terminator
        srcmem_a[0] = 32'h11;
        srcmem_a[1] = 32'h22;
        srcmem_a[2] = EndWord;
        load_a("prog3");
        chk("prog3_done_idle", 64'(done_a), 64'd1);

        fetch_a(32'd0, 1'b1, "f0");
        fetch_a(32'd4, 1'b1, "f4");
        fetch_a(32'd8, 1'b1, "f8");
        fetch_a(32'd8, 1'b0, "fidle");

        // Requests outside EXEC, including an unused mode code, are ignored
        mode_a = ModeStall;
        req_a  = 1'b1;
        tick();
        chk("stall_req_valid", 64'(inst_valid_a), 64'd0);
        mode_a = 3'd5;
        tick();
        chk("mode5_req_valid", 64'(inst_valid_a), 64'd0);
        chk("mode5_req_inst", 64'(inst_a), 64'(exp_inst_a));

`ifdef FETCH_BOUNDS_EN
        fetch_a(32'd12, 1'b1, "oob12");
        fetch_a(32'd2, 1'b1, "misalign2");
`else
        fetch_a(32'h0001_0004, 1'b1, "wrap_hi");
        fetch_a(32'hFFFF_0003, 1'b1, "wrap_lo");
`endif

        // Randomised programs and fetch streams
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(20, 1);
            for (int i = 0; i < int'(len) - 1; i++) srcmem_a[i] = rnd_word();
            srcmem_a[len-1] = EndWord;
            load_a($sformatf("rnd%0d", it));
            for (int j = 0; j < 20; j++) begin
                idx = $urandom_range(len - 1, 0);
`ifdef FETCH_BOUNDS_EN
                p = idx << 2;
`else
                p = ($urandom & 32'hFFFF_0000) | (idx << 2) | ($urandom % 4);
`endif
                fetch_a(p, 1'($urandom % 2), $sformatf("rnd%0d_f%0d", it, j));
            end
        end

        // Abort after the second stored word, then reload from scratch
        for (int i = 0; i < 5; i++) srcmem_a[i] = rnd_word();
        srcmem_a[5] = EndWord;
        mode_a = ModeLoad;
        tick();
        k = 0;
        while (load_count_a !== 15'd2 && k < 100) begin
            tick();
            k++;
        end
        mode_a = ModeStall;
        tick();
        chk("abort_done", 64'(done_a), 64'd0);
        chk("abort_count", 64'(load_count_a), 64'd2);
        chk("abort_src_addr", 64'(src_addr_a), 64'd1);
        tick();
        chk("abort_count_hold", 64'(load_count_a), 64'd2);
        load_a("reload");
        fetch_a(32'd20, 1'b1, "reload_f5");

        // Tiny instance: no terminator in source, load stops when memory is full
        mode_b = ModeLoad;
        tick();
        edges = 1;
        while (done_b !== 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
        chk("full_cycles", 64'(edges), 64'(1 + 4 * (3 + 2)));
        chk("full_count", 64'(load_count_b), 64'd4);
        mode_b = ModeExec;
        for (int i = 0; i < 4; i++) begin
            pc_b  = ($urandom & 32'hFFFF_FFF0) | (32'(i) << 2);
            req_b = 1'b1;
            tick();
            chk($sformatf("full_f%0d_valid", i), 64'(inst_valid_b), 64'd1);
            chk($sformatf("full_f%0d_inst", i), 64'(inst_b), 64'(srcmem_b[i]));
            chk($sformatf("full_f%0d_fault", i), 64'(fault_b), 64'd0);
        end
        req_b = 1'b0;
        tick();
        chk("full_idle_valid", 64'(inst_valid_b), 64'd0);
        chk("full_idle_inst", 64'(inst_b), 64'(srcmem_b[3]));
        mode_b = ModeStall;

        // Asynchronous reset while waiting on the source for the third word
        for (int i = 0; i < 5; i++) srcmem_a[i] = rnd_word();
        srcmem_a[5] = EndWord;
        mode_a = ModeLoad;
        req_a  = 1'b0;
        tick();
        k = 0;
        while (load_count_a !== 15'd2 && k < 100) begin
            tick();
            k++;
        end
        chk("rstw_pre_count", 64'(load_count_a), 64'd2);
        tick();
        #1 rstn = 1'b0;
        #1;
        model_mem_a[0] = srcmem_a[0];
        model_mem_a[1] = srcmem_a[1];
        exp_cnt_a  = 0;
        exp_fault  = 1'b0;
        exp_inst_a = '0;
        chk("rstw_src_addr", 64'(src_addr_a), 64'd0);
        chk("rstw_count", 64'(load_count_a), 64'd0);
        chk("rstw_done", 64'(done_a), 64'd0);
        chk("rstw_inst", 64'(inst_a), 64'd0);
        chk("rstw_valid", 64'(inst_valid_a), 64'd0);
        chk("rstw_fault", 64'(fault_a), 64'd0);
        chk("rstw_b_done", 64'(done_b), 64'd0);
        chk("rstw_b_inst", 64'(inst_b), 64'd0);
        mode_a = ModeStall;
        #1 rstn = 1'b1;
        tick();
        fetch_a(32'd0, 1'b1, "retain0");
        fetch_a(32'd4, 1'b1, "retain1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
